bht_predictor_nway: RTL and testbench
=====================================

Name: bht_predictor_nway

Overview:
- Parametrised N-way set-associative branch history table with saturating-counter prediction for the RV32IMC pipeline.
- IF stage: looks up the PC and predicts taken/target. ID stage: allocates branches and jumps that are not yet in the table. EXE stage: resolves the branch, trains the counter, issues PC corrections and flushes.
- Adds over the previous generation: configurable sets, ways, PC width and counter width; a selectable replacement mode; same-cycle allocate and update; performance counters.

Parameters:
- PC_W, 11, halfword PC width.
- SETS, 16, number of sets (power of 2). IDX_W = log2(SETS).
- WAYS, 4, ways per set (power of 2, 1..8).
- CTR_W, 2, saturating counter width (2..4).
- REPL, 0, replacement mode. 0 = pure FIFO. 1 = fill the lowest-index invalid way first, else FIFO.

Ports:
- CLK  in  1  clock
- nrst  in  1  synchronous active-low reset
- en  in  1  global enable
- stall  in  1  pipeline stall; freezes all state
- isr_running  in  1  appended as tag MSB
- if_pc  in  PC_W  IF-stage PC
- id_pc  in  PC_W  ID-stage PC
- id_target  in  PC_W  decoded target
- id_is_branch  in  1  conditional branch in ID
- id_is_jump  in  1  jump in ID
- exe_pc  in  PC_W  EXE-stage PC
- exe_is_branch  in  1  conditional branch resolving in EXE
- exe_taken  in  1  resolved outcome
- exe_target  in  PC_W  computed target
- exe_is_c  in  1  compressed instruction
- if_hit  out  1  IF lookup hit
- if_prediction  out  1  predicted taken
- if_pbt  out  PC_W  predicted target
- exe_correction  out  2  00 = none, 10 = take exe_cni, 11 = take exe_pbt
- exe_pbt  out  PC_W  correct taken target
- exe_cni  out  PC_W  fall-through address
- flush  out  1  flush IF/ID
- id_jump_in_bht  out  1  jump in ID hits the table
- branch_count  out  32  resolved branches
- mispredict_count  out  32  mispredictions

Behaviour:
- Entry format: valid, tag = {isr_running, pc[PC_W-1:IDX_W]}, target[PC_W], ctr[CTR_W]. Set index = pc[IDX_W-1:0].
- Lookups in IF, ID and EXE are combinational. Hit = valid && tag equal. At most one way matches.
- if_prediction = ctr MSB on a hit, else 0. if_pbt = stored target on a hit, else 0.
- State writes occur only when en && !stall && nrst.
- Allocation: when (id_is_branch | id_is_jump) and the ID lookup misses, write {1, tag, id_target, init} into the victim way.
  - init = all-ones for a jump; 2^(CTR_W-1)-1 (weakly not-taken) for a branch.
  - Victim with REPL=0: the per-set pointer, which then increments modulo WAYS.
  - Victim with REPL=1: the lowest-index invalid way if one exists, with the pointer unchanged; otherwise the pointer, which then increments.
- Training: when exe_is_branch and the EXE lookup hits, ctr increments if taken and decrements if not, saturating at 0 and at 2^CTR_W-1. When taken and the stored target differs from exe_target, the target is rewritten.
- Simultaneous allocate and train: both are performed unless they address the same set and way. In that case the allocation wins and the training is dropped.
- EXE prediction = ctr MSB on a hit, else 0. Mispredict = exe_is_branch && (prediction != exe_taken).
  - exe_correction = 00 if no mispredict.
  - exe_correction = 11 if mispredict and exe_taken.
  - exe_correction = 10 if mispredict and not exe_taken.
- exe_cni = exe_pc + (exe_is_c ? 1 : 2), modulo 2^PC_W. exe_pbt = exe_target.
- Flush:
  - Register flush_state updates only when en && !stall.
  - If flush_state=1: flush=1 and next flush_state=0.
  - Else if mispredict: flush=1 and next flush_state=1.
  - Else: flush=0, and next flush_state = (id_is_jump && ID miss).
- id_jump_in_bht = id_is_jump && ID hit.
- Performance counters:
  - branch_count increments on each exe_is_branch with en && !stall.
  - mispredict_count increments on each mispredict with en && !stall.
  - Both saturate at 32'hFFFFFFFF.
- Reset (nrst=0 at a CLK edge, including mid-operation):
  - Clears all valid bits, pointers, flush_state and both counters.
  - Resulting outputs: if_hit=0, if_prediction=0, exe_correction=00 unless exe_is_branch && exe_taken, flush=0, counters=0.
  - Table contents are not required to be zeroed beyond the valid bits.

Test Plan:
- Reset, then present branch id_pc=0x013, target 0x040, for one cycle. Next cycle if_pc=0x013 gives if_hit=1, if_prediction=0, if_pbt=0x040. Then exe_is_branch=1, taken=1 twice gives ctr 01→10→11 and if_prediction=1 after the first update.
- Allocate 5 distinct branches to set 3 (pcs 0x003, 0x013, 0x023, 0x033, 0x043) with REPL=0. The 5th evicts 0x003, so if_pc=0x003 misses and 0x013 hits.
- With REPL=1: allocate 0x003, 0x013, then invalidate via reset, then allocate 0x023. It lands in way 0, and the pointer stays 0.
- Mispredict at exe_pc=0x100, predicted not-taken, taken=1, exe_is_c=0. Required: exe_correction=11, flush high for exactly 2 cycles, mispredict_count +1. With taken=0 on a predicted-taken entry: exe_correction=10, exe_cni=0x102 (0x101 when exe_is_c=1).
- Jump missing in ID: flush=0 this cycle, flush=1 next cycle, id_jump_in_bht=0. The same jump later gives id_jump_in_bht=1 and no flush. Holding stall=1 freezes flush_state and the table.
- Same cycle: allocate set 5 way 2 while training set 5 way 2. Only the allocation is visible. Training set 6 in the same cycle is applied.

Source files
------------

// File: rtl/bht_predictor_nway.sv
// bht_predictor_nway: N-way set-associative branch history table with saturating-counter prediction
module bht_predictor_nway #(
  parameter int PC_W  = 11,
  parameter int SETS  = 16,
  parameter int WAYS  = 4,
  parameter int CTR_W = 2,
  parameter int REPL  = 0
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            en,
  input  logic            stall,
  input  logic            isr_running,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] id_pc,
  input  logic [PC_W-1:0] id_target,
  input  logic            id_is_branch,
  input  logic            id_is_jump,
  input  logic [PC_W-1:0] exe_pc,
  input  logic            exe_is_branch,
  input  logic            exe_taken,
  input  logic [PC_W-1:0] exe_target,
  input  logic            exe_is_c,
  output logic            if_hit,
  output logic            if_prediction,
  output logic [PC_W-1:0] if_pbt,
  output logic [1:0]      exe_correction,
  output logic [PC_W-1:0] exe_pbt,
  output logic [PC_W-1:0] exe_cni,
  output logic            flush,
  output logic            id_jump_in_bht,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W + 1;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);

  logic [WAYS-1:0]  valid_q [SETS], valid_d [SETS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS], tag_d [SETS][WAYS];
  logic [PC_W-1:0]  tgt_q [SETS][WAYS], tgt_d [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q [SETS][WAYS], ctr_d [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q [SETS], ptr_d [SETS];
  logic             flush_q, flush_d;
  logic [31:0]      bc_q, bc_d, mc_q, mc_d;

  logic [IDX_W-1:0] if_set, id_set, exe_set;
  logic [TAG_W-1:0] if_tag, id_tag, exe_tag;
  logic             if_h, id_h, exe_h, inv_any, exe_pred, mis, alloc, fifo;
  logic [WAY_W-1:0] if_w, exe_w, inv_w, vic;

  // tag match in all three stages plus lowest invalid way of the ID set
  always_comb begin
    if_set = if_pc[IDX_W-1:0];
    id_set = id_pc[IDX_W-1:0];
    exe_set = exe_pc[IDX_W-1:0];
    if_tag = {isr_running, if_pc[PC_W-1:IDX_W]};
    id_tag = {isr_running, id_pc[PC_W-1:IDX_W]};
    exe_tag = {isr_running, exe_pc[PC_W-1:IDX_W]};
    if_h = 1'b0;
    id_h = 1'b0;
    exe_h = 1'b0;
    if_w = '0;
    exe_w = '0;
    inv_any = 1'b0;
    inv_w = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[if_set][w] && tag_q[if_set][w] == if_tag) begin
        if_h = 1'b1;
        if_w = WAY_W'(w);
      end
      if (valid_q[id_set][w] && tag_q[id_set][w] == id_tag) id_h = 1'b1;
      if (valid_q[exe_set][w] && tag_q[exe_set][w] == exe_tag) begin
        exe_h = 1'b1;
        exe_w = WAY_W'(w);
      end
      if (!valid_q[id_set][w]) begin
        inv_any = 1'b1;
        inv_w = WAY_W'(w);
      end
    end
  end

  assign if_hit = if_h;
  assign if_prediction = if_h & ctr_q[if_set][if_w][CTR_W-1];
  assign if_pbt = if_h ? tgt_q[if_set][if_w] : '0;
  assign exe_pred = exe_h & ctr_q[exe_set][exe_w][CTR_W-1];
  assign mis = exe_is_branch & (exe_pred != exe_taken);
  assign exe_correction = {mis, mis & exe_taken};
  assign exe_pbt = exe_target;
  assign exe_cni = exe_pc + (exe_is_c ? PC_W'(1) : PC_W'(2));
  assign flush = flush_q | mis;
  assign id_jump_in_bht = id_is_jump & id_h;
  assign branch_count = bc_q;
  assign mispredict_count = mc_q;

  // allocation, training (dropped when it hits the slot being allocated), flush and counters
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    ptr_d = ptr_q;
    alloc = (id_is_branch | id_is_jump) & ~id_h;
    fifo = !(REPL == 1 && inv_any);
    vic = fifo ? ptr_q[id_set] : inv_w;
    if (exe_is_branch && exe_h && !(alloc && id_set == exe_set && vic == exe_w)) begin
      ctr_d[exe_set][exe_w] = exe_taken ?
        (ctr_q[exe_set][exe_w] == CTR_MAX ? CTR_MAX : ctr_q[exe_set][exe_w] + 1'b1) :
        (ctr_q[exe_set][exe_w] == '0 ? '0 : ctr_q[exe_set][exe_w] - 1'b1);
      if (exe_taken) tgt_d[exe_set][exe_w] = exe_target;
    end
    if (alloc) begin
      valid_d[id_set][vic] = 1'b1;
      tag_d[id_set][vic] = id_tag;
      tgt_d[id_set][vic] = id_target;
      ctr_d[id_set][vic] = id_is_jump ? CTR_MAX : CTR_WNT;
      if (fifo) ptr_d[id_set] = ptr_q[id_set] == WAY_LAST ? '0 : ptr_q[id_set] + 1'b1;
    end
    flush_d = flush_q ? 1'b0 : mis ? 1'b1 : id_is_jump & ~id_h;
    bc_d = (exe_is_branch && ~&bc_q) ? bc_q + 1 : bc_q;
    mc_d = (mis && ~&mc_q) ? mc_q + 1 : mc_q;
  end

  // state register; reset clears valid bits, pointers, flush state and counters only
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      valid_q <= '{default: '0};
      ptr_q <= '{default: '0};
      flush_q <= 1'b0;
      bc_q <= '0;
      mc_q <= '0;
    end else if (en && !stall) begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
      ptr_q <= ptr_d;
      flush_q <= flush_d;
      bc_q <= bc_d;
      mc_q <= mc_d;
    end
  end
endmodule

// File: tb/tb_bht_predictor_nway.sv
// tb_bht_predictor_nway: directed bench with a table-level reference model for both replacement modes
module tb_bht_predictor_nway;
  localparam int PC_W = 11, SETS = 16, WAYS = 4, CTR_W = 2;
  logic CLK = 0, nrst = 0, en = 1, stall = 0, isr_running = 0;
  logic [PC_W-1:0] if_pc = 0, id_pc = 0, id_target = 0, exe_pc = 0, exe_target = 0;
  logic id_is_branch = 0, id_is_jump = 0, exe_is_branch = 0, exe_taken = 0, exe_is_c = 0;
  logic if_hit_o [2], if_pred_o [2], flush_o [2], ijb_o [2];
  logic [PC_W-1:0] if_pbt_o [2], exe_pbt_o [2], exe_cni_o [2];
  logic [1:0] corr_o [2];
  logic [31:0] bc_o [2], mc_o [2];
  int pass = 0, total = 0;
  bit started = 0;

  bit m_v [2][SETS][WAYS];
  int m_tag [2][SETS][WAYS], m_tgt [2][SETS][WAYS], m_ctr [2][SETS][WAYS];
  int m_ptr [2][SETS];
  bit m_fs [2];
  longint m_bc [2], m_mc [2];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bht_predictor_nway #(.PC_W(PC_W), .SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W), .REPL(g)) dut (
      .CLK(CLK), .nrst(nrst), .en(en), .stall(stall), .isr_running(isr_running),
      .if_pc(if_pc), .id_pc(id_pc), .id_target(id_target), .id_is_branch(id_is_branch),
      .id_is_jump(id_is_jump), .exe_pc(exe_pc), .exe_is_branch(exe_is_branch),
      .exe_taken(exe_taken), .exe_target(exe_target), .exe_is_c(exe_is_c),
      .if_hit(if_hit_o[g]), .if_prediction(if_pred_o[g]), .if_pbt(if_pbt_o[g]),
      .exe_correction(corr_o[g]), .exe_pbt(exe_pbt_o[g]), .exe_cni(exe_cni_o[g]),
      .flush(flush_o[g]), .id_jump_in_bht(ijb_o[g]),
      .branch_count(bc_o[g]), .mispredict_count(mc_o[g]));
  end

  task automatic chk(input string n, input int r, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s dut%0d at %0t: got %h expected %h", n, r, $time, a, e);
    else pass++;
  endtask

  function automatic int look(input int r, input int pc);
    int s = pc % SETS;
    int t = (int'(isr_running) << (PC_W - 4)) | (pc >> 4);
    for (int w = 0; w < WAYS; w++) if (m_v[r][s][w] && m_tag[r][s][w] == t) return w;
    return -1;
  endfunction

  // model: check every cycle against table rules, then advance the table by one edge
  always @(negedge CLK) begin
    int iw, dw, ew, ep, ms, s, es, vic, inv, t;
    for (int r = 0; r < 2; r++) begin
      iw = look(r, int'(if_pc));
      dw = look(r, int'(id_pc));
      ew = look(r, int'(exe_pc));
      ep = ew >= 0 ? m_ctr[r][exe_pc % SETS][ew] >> (CTR_W - 1) : 0;
      ms = int'(exe_is_branch) & int'(ep != int'(exe_taken));
      if (started) begin
        chk("if_hit", r, 32'(if_hit_o[r]), 32'(iw >= 0));
        chk("if_prediction", r, 32'(if_pred_o[r]), iw >= 0 ? 32'(m_ctr[r][if_pc % SETS][iw] >> (CTR_W - 1)) : 0);
        chk("if_pbt", r, 32'(if_pbt_o[r]), iw >= 0 ? 32'(m_tgt[r][if_pc % SETS][iw]) : 0);
        chk("id_jump_in_bht", r, 32'(ijb_o[r]), 32'(id_is_jump && dw >= 0));
        chk("exe_correction", r, 32'(corr_o[r]), ms ? (exe_taken ? 3 : 2) : 0);
        chk("exe_pbt", r, 32'(exe_pbt_o[r]), 32'(exe_target));
        chk("exe_cni", r, 32'(exe_cni_o[r]), (exe_pc + (exe_is_c ? 1 : 2)) % (1 << PC_W));
        chk("flush", r, 32'(flush_o[r]), 32'(m_fs[r] || ms));
        chk("branch_count", r, bc_o[r], 32'(m_bc[r]));
        chk("mispredict_count", r, mc_o[r], 32'(m_mc[r]));
      end
      if (!nrst) begin
        m_v[r] = '{default: 0};
        m_ptr[r] = '{default: 0};
        m_fs[r] = 0;
        m_bc[r] = 0;
        m_mc[r] = 0;
      end else if (en && !stall) begin
        s = id_pc % SETS;
        es = exe_pc % SETS;
        inv = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_v[r][s][w]) inv = w;
        vic = (r == 1 && inv >= 0) ? inv : m_ptr[r][s];
        t = (int'(isr_running) << (PC_W - 4)) | (id_pc >> 4);
        if (exe_is_branch && ew >= 0 && !((id_is_branch || id_is_jump) && dw < 0 && s == es && vic == ew)) begin
          if (exe_taken) begin
            m_ctr[r][es][ew] = m_ctr[r][es][ew] < (1 << CTR_W) - 1 ? m_ctr[r][es][ew] + 1 : m_ctr[r][es][ew];
            m_tgt[r][es][ew] = exe_target;
          end else if (m_ctr[r][es][ew] > 0) m_ctr[r][es][ew]--;
        end
        if ((id_is_branch || id_is_jump) && dw < 0) begin
          m_v[r][s][vic] = 1;
          m_tag[r][s][vic] = t;
          m_tgt[r][s][vic] = id_target;
          m_ctr[r][s][vic] = id_is_jump ? (1 << CTR_W) - 1 : (1 << (CTR_W - 1)) - 1;
          if (!(r == 1 && inv >= 0)) m_ptr[r][s] = (m_ptr[r][s] + 1) % WAYS;
        end
        m_fs[r] = m_fs[r] ? 0 : ms ? 1 : (id_is_jump && dw < 0);
        if (exe_is_branch && m_bc[r] < 64'hFFFFFFFF) m_bc[r]++;
        if (ms && m_mc[r] < 64'hFFFFFFFF) m_mc[r]++;
      end
    end
    if (!nrst) started = 1;
  end

  task automatic clr();
    isr_running = 0; stall = 0; en = 1;
    if_pc = 0; id_pc = 0; id_target = 0; exe_pc = 0; exe_target = 0;
    id_is_branch = 0; id_is_jump = 0; exe_is_branch = 0; exe_taken = 0; exe_is_c = 0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1 clr();
  endtask

  task automatic rst();
    nrst = 0;
    nxt();
    nrst = 1;
  endtask

  task automatic br(input int pc, input int tg);
    id_pc = PC_W'(pc); id_target = PC_W'(tg); id_is_branch = 1;
    nxt();
  endtask

  task automatic hit_both(input string n, input int pc, input bit e);
    if_pc = PC_W'(pc);
    #1;
    for (int r = 0; r < 2; r++) chk(n, r, 32'(if_hit_o[r]), 32'(e));
  endtask

  initial begin
    rst();
    rst();
    #1 chk("rst_if_hit", 0, 32'(if_hit_o[0]), 0);
    chk("rst_flush", 0, 32'(flush_o[0]), 0);
    chk("rst_count", 0, bc_o[0], 0);
    id_pc = 'h013; id_is_branch = 1; id_target = 'h040; if_pc = 'h013;
    #1 chk("pre_alloc_hit", 0, 32'(if_hit_o[0]), 0);
    nxt();
    if_pc = 'h013; exe_pc = 'h013; exe_is_branch = 1; exe_taken = 1; exe_target = 'h040;
    #1 chk("alloc_hit", 0, 32'(if_hit_o[0]), 1);
    chk("alloc_pred", 0, 32'(if_pred_o[0]), 0);
    chk("alloc_pbt", 0, 32'(if_pbt_o[0]), 'h040);
    chk("first_train_corr", 0, 32'(corr_o[0]), 3);
    nxt();
    if_pc = 'h013; exe_pc = 'h013; exe_is_branch = 1; exe_taken = 1; exe_target = 'h040;
    #1 chk("trained_pred", 0, 32'(if_pred_o[0]), 1);
    chk("second_train_corr", 0, 32'(corr_o[0]), 0);
    chk("flush_tail", 0, 32'(flush_o[0]), 1);
    nxt();
    if_pc = 'h013;
    #1 chk("flush_done", 0, 32'(flush_o[0]), 0);
    chk("branch_count", 0, bc_o[0], 2);
    chk("mispredict_count", 0, mc_o[0], 1);
    isr_running = 1;
    #1 chk("isr_tag_miss", 0, 32'(if_hit_o[0]), 0);
    nxt();

    rst();
    for (int i = 0; i < 5; i++) br('h003 + 16 * i, 'h103 + 16 * i);
    hit_both("evicted_003", 'h003, 0);
    hit_both("kept_013", 'h013, 1);
    #1 chk("kept_013_pbt", 0, 32'(if_pbt_o[0]), 'h113);
    nxt();

    rst();
    br('h003, 'h1);
    br('h013, 'h2);
    rst();
    br('h023, 'h3);
    hit_both("refill_023", 'h023, 1);
    nxt();
    for (int i = 0; i < 3; i++) br('h033 + 16 * i, 'h4 + i);
    br('h063, 'h7);
    hit_both("ptr0_evict_023", 'h023, 0);
    hit_both("ptr0_keep_033", 'h033, 1);
    nxt();

    rst();
    exe_pc = 'h100; exe_is_branch = 1; exe_taken = 1; exe_target = 'h155;
    #1 chk("mis_taken_corr", 0, 32'(corr_o[0]), 3);
    chk("mis_pbt", 0, 32'(exe_pbt_o[0]), 'h155);
    chk("mis_cni", 0, 32'(exe_cni_o[0]), 'h102);
    chk("mis_flush0", 0, 32'(flush_o[0]), 1);
    nxt();
    #1 chk("mis_flush1", 0, 32'(flush_o[0]), 1);
    nxt();
    #1 chk("mis_flush2", 0, 32'(flush_o[0]), 0);
    chk("mis_count", 0, mc_o[0], 1);
    id_pc = 'h120; id_is_jump = 1; id_target = 'h180;
    nxt();
    nxt();
    exe_pc = 'h120; exe_is_branch = 1; exe_taken = 0; exe_is_c = 1; exe_target = 'h180;
    #1 chk("mis_nt_corr", 0, 32'(corr_o[0]), 2);
    chk("mis_nt_cni_c", 0, 32'(exe_cni_o[0]), 'h121);
    nxt();
    exe_pc = 'h120; exe_is_branch = 1; exe_taken = 0; exe_target = 'h180;
    #1 chk("mis_nt_corr2", 0, 32'(corr_o[0]), 2);
    chk("mis_nt_cni", 0, 32'(exe_cni_o[0]), 'h122);
    nxt();

    rst();
    id_pc = 'h200; id_is_jump = 1; id_target = 'h300;
    #1 chk("jmp_miss_flush", 0, 32'(flush_o[0]), 0);
    chk("jmp_miss_ijb", 0, 32'(ijb_o[0]), 0);
    nxt();
    #1 chk("jmp_late_flush", 0, 32'(flush_o[0]), 1);
    nxt();
    id_pc = 'h200; id_is_jump = 1;
    #1 chk("jmp_hit_ijb", 0, 32'(ijb_o[0]), 1);
    chk("jmp_hit_flush", 0, 32'(flush_o[0]), 0);
    nxt();
    #1 chk("jmp_hit_noflush", 0, 32'(flush_o[0]), 0);
    stall = 1; id_pc = 'h210; id_is_jump = 1; id_target = 'h310;
    nxt();
    stall = 1;
    #1 chk("stall_flush", 0, 32'(flush_o[0]), 0);
    nxt();
    id_pc = 'h210; id_is_jump = 1; stall = 1;
    #1 chk("stall_no_alloc", 0, 32'(ijb_o[0]), 0);
    nxt();

    rst();
    for (int i = 0; i < 6; i++) br('h005 + 16 * i, 'h105 + 16 * i);
    br('h006, 'h106);
    id_pc = 'h065; id_is_branch = 1; id_target = 'h0AA;
    exe_pc = 'h025; exe_is_branch = 1; exe_taken = 1; exe_target = 'h111;
    nxt();
    hit_both("coll_evict_025", 'h025, 0);
    hit_both("coll_alloc_065", 'h065, 1);
    #1 chk("coll_pbt", 0, 32'(if_pbt_o[0]), 'h0AA);
    chk("coll_pred", 1, 32'(if_pred_o[1]), 0);
    id_pc = 'h075; id_is_branch = 1; id_target = 'h0BB;
    exe_pc = 'h006; exe_is_branch = 1; exe_taken = 1; exe_target = 'h106;
    nxt();
    if_pc = 'h006;
    #1 chk("other_set_trained", 0, 32'(if_pred_o[0]), 1);
    hit_both("evict_035", 'h035, 0);
    en = 0; id_pc = 'h0F7; id_is_branch = 1; id_target = 'h1;
    nxt();
    hit_both("en_low_no_alloc", 'h0F7, 0);
    nxt();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
